// File: rtl/operand2_encoder.sv
// operand2_encoder: searches for the ARM rotated-immediate operand-2 form
// {rot4, imm8} of a 32-bit constant, one rotation per clock, under a
// start/done handshake.
// Optional feature macro: OPERAND2_INVERT_EN also accepts constants whose
// bitwise complement is encodable, flagged through the 'inverted' output.
module operand2_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [7:0]  imm8,
  output logic [3:0]  rot4,
  output logic [11:0] encoding,
  output logic        inverted
);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t      state_q, state_n;
  logic [3:0]  r_q, r_n;
  logic [31:0] v_q, v_n;
  logic        done_q, done_n;
  logic        valid_q, valid_n;
  logic [7:0]  imm8_q, imm8_n;
  logic [3:0]  rot4_q, rot4_n;
  logic        inv_q, inv_n;

  logic [31:0] cand;
  logic [31:0] candi;
  logic        match_d;
  logic        match_i;

  // 32-bit rotate left; a zero shift leaves x unchanged because x >> 32 is 0.
  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] sh);
    logic [5:0] rsh;
    rsh   = 6'd32 - {1'b0, sh};
    rol32 = (x << sh) | (x >> rsh);
  endfunction

  // Candidate for the current rotation: undoing ROR by 2r is ROL by 2r.
  always_comb begin
    cand    = rol32(v_q, {r_q, 1'b0});
    candi   = rol32(~v_q, {r_q, 1'b0});
    match_d = (cand[31:8] == 24'd0);
`ifdef OPERAND2_INVERT_EN
    match_i = (candi[31:8] == 24'd0);
`else
    match_i = 1'b0;
`endif
  end

  // State register and result registers; reset clears everything and
  // abandons any search in flight without emitting done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= 4'd0;
      v_q     <= 32'd0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      imm8_q  <= 8'd0;
      rot4_q  <= 4'd0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      r_q     <= r_n;
      v_q     <= v_n;
      done_q  <= done_n;
      valid_q <= valid_n;
      imm8_q  <= imm8_n;
      rot4_q  <= rot4_n;
      inv_q   <= inv_n;
    end
  end

  // Next-state logic: lowest rotation wins, direct form before inverted form.
  always_comb begin
    state_n = state_q;
    r_n     = r_q;
    v_n     = v_q;
    done_n  = 1'b0;
    valid_n = valid_q;
    imm8_n  = imm8_q;
    rot4_n  = rot4_q;
    inv_n   = inv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          v_n     = value;
          r_n     = 4'd0;
          state_n = SEARCH;
        end
      end
      SEARCH: begin
        if (match_d) begin
          imm8_n  = cand[7:0];
          rot4_n  = r_q;
          valid_n = 1'b1;
          inv_n   = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (match_i) begin
          imm8_n  = candi[7:0];
          rot4_n  = r_q;
          valid_n = 1'b1;
          inv_n   = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (r_q == 4'd15) begin
          imm8_n  = 8'd0;
          rot4_n  = 4'd0;
          valid_n = 1'b0;
          inv_n   = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          r_n = r_q + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy     = (state_q == SEARCH);
  assign done     = done_q;
  assign valid    = valid_q;
  assign imm8     = imm8_q;
  assign rot4     = rot4_q;
  assign encoding = {rot4_q, imm8_q};
  assign inverted = inv_q;

endmodule
